// File: rtl/airlock_pkg.sv
// Shared types and constants for the airlock sequencer.
// State encoding used by airlock_sequencer; FAULT is reachable only with AIRLOCK_SEAL_TIMEOUT_EN.
package airlock_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      REST_P   = 3'd0,
      REST_V   = 3'd1,
      OPEN_IN  = 3'd2,
      OPEN_OUT = 3'd3,
      SEAL     = 3'd4,
      EVAC     = 3'd5,
      PRESS    = 3'd6,
      FAULT    = 3'd7
   } state_e;

   // Both door sensors report closed; gates every pump start.
   function automatic logic doors_closed(input logic inner_closed, input logic outer_closed);
      return inner_closed & outer_closed;
   endfunction

endpackage

// File: rtl/airlock_timer.sv
// Down-counter shared by the pump phases and the seal wait of the airlock sequencer.
// done is high while the count sits at zero; load has priority over en.
module airlock_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/airlock_sequencer.sv
// Two-door airlock sequencer: interlocked door commands and evacuation/pressurization pumps.
// Optional macro AIRLOCK_SEAL_TIMEOUT_EN adds a seal timeout that latches a FAULT state.
module airlock_sequencer
   import airlock_pkg::*;
#(
   parameter int EVAC_CYCLES  = 8,
   parameter int PRESS_CYCLES = 8,
   parameter int SEAL_TIMEOUT = 16,
   parameter int CNT_W        = 8
) (
   input  logic Clock,
   input  logic Reset,
   input  logic inner_req,
   input  logic outer_req,
   input  logic InnerClosed,
   input  logic OuterClosed,
   output logic open_inner,
   output logic open_outer,
   output logic pump_evac,
   output logic pump_press,
   output logic chamber_vac,
   output logic busy,
   output logic fault
);

   // The timer is loaded with N-1 so that done coincides with the Nth cycle in the phase,
   // giving exactly N cycles of pump or seal wait before the exit edge.
   localparam logic [CNT_W-1:0] EVAC_LD  = CNT_W'(EVAC_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] SEAL_LD  = CNT_W'(SEAL_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic             vac_q, vac_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_en;
   logic             tmr_done;
   logic             closed;

   assign closed = doors_closed(InnerClosed, OuterClosed);

   airlock_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk_i     (Clock),
      .rst_ni    (Reset),
      .load_i    (tmr_load),
      .load_val_i(tmr_load_val),
      .en_i      (tmr_en),
      .done_o    (tmr_done)
   );

   always_comb begin
      state_d      = state_q;
      vac_d        = vac_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_en       = 1'b0;
      unique case (state_q)
         REST_P: begin
            if (inner_req) begin
               state_d = OPEN_IN;
            end else if (outer_req && closed) begin
               state_d      = EVAC;
               tmr_load     = 1'b1;
               tmr_load_val = EVAC_LD;
            end
         end
         REST_V: begin
            if (outer_req) begin
               state_d = OPEN_OUT;
            end else if (inner_req && closed) begin
               state_d      = PRESS;
               tmr_load     = 1'b1;
               tmr_load_val = PRESS_LD;
            end
         end
         OPEN_IN: begin
            if (!inner_req) begin
               state_d      = SEAL;
               tmr_load     = 1'b1;
               tmr_load_val = SEAL_LD;
            end
         end
         OPEN_OUT: begin
            if (!outer_req) begin
               state_d      = SEAL;
               tmr_load     = 1'b1;
               tmr_load_val = SEAL_LD;
            end
         end
         SEAL: begin
            tmr_en = 1'b1;
            if (closed) begin
               state_d = vac_q ? REST_V : REST_P;
`ifdef AIRLOCK_SEAL_TIMEOUT_EN
            end else if (tmr_done) begin
               state_d = FAULT;
`endif
            end
         end
         // A door sensor opening mid-pump wins over expiry: stop pumping, keep vac_flag.
         EVAC: begin
            tmr_en = 1'b1;
            if (!closed) begin
               state_d      = SEAL;
               tmr_load     = 1'b1;
               tmr_load_val = SEAL_LD;
            end else if (tmr_done) begin
               state_d = REST_V;
               vac_d   = 1'b1;
            end
         end
         PRESS: begin
            tmr_en = 1'b1;
            if (!closed) begin
               state_d      = SEAL;
               tmr_load     = 1'b1;
               tmr_load_val = SEAL_LD;
            end else if (tmr_done) begin
               state_d = REST_P;
               vac_d   = 1'b0;
            end
         end
         FAULT: begin
`ifdef AIRLOCK_SEAL_TIMEOUT_EN
            state_d = FAULT;
`else
            state_d = REST_P;
`endif
         end
         default: begin
            state_d = REST_P;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= REST_P;
         vac_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vac_q   <= vac_d;
      end
   end

   always_comb begin
      open_inner  = (state_q == OPEN_IN);
      open_outer  = (state_q == OPEN_OUT);
      pump_evac   = (state_q == EVAC);
      pump_press  = (state_q == PRESS);
      chamber_vac = vac_q;
      busy        = (state_q != REST_P) && (state_q != REST_V);
   end

`ifdef AIRLOCK_SEAL_TIMEOUT_EN
   assign fault = (state_q == FAULT);
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer: a cycle table plus hand-written corner sequences.
module tb_airlock_sequencer;

   localparam int EVAC_C  = 4;
   localparam int PRESS_C = 3;
   localparam int SEAL_T  = 16;
   localparam int CW      = 8;

   // Output bit order: open_inner open_outer pump_evac pump_press chamber_vac busy fault
   localparam logic [6:0] O_IDLE_P = 7'b0000000;
   localparam logic [6:0] O_OPENI  = 7'b1000010;
   localparam logic [6:0] O_SEAL_P = 7'b0000010;
   localparam logic [6:0] O_EVAC   = 7'b0010010;
   localparam logic [6:0] O_IDLE_V = 7'b0000100;
   localparam logic [6:0] O_OPENO  = 7'b0100110;
   localparam logic [6:0] O_SEAL_V = 7'b0000110;
   localparam logic [6:0] O_PRESS  = 7'b0001110;
   localparam logic [6:0] O_FAULT  = 7'b0000011;

   logic Clock = 1'b0;
   logic Reset;
   logic inner_req, outer_req, InnerClosed, OuterClosed;
   logic open_inner, open_outer, pump_evac, pump_press, chamber_vac, busy, fault;

   int checks   = 0;
   int failures = 0;

   always #5 Clock = ~Clock;

   airlock_sequencer #(
      .EVAC_CYCLES (EVAC_C),
      .PRESS_CYCLES(PRESS_C),
      .SEAL_TIMEOUT(SEAL_T),
      .CNT_W       (CW)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .inner_req  (inner_req),
      .outer_req  (outer_req),
      .InnerClosed(InnerClosed),
      .OuterClosed(OuterClosed),
      .open_inner (open_inner),
      .open_outer (open_outer),
      .pump_evac  (pump_evac),
      .pump_press (pump_press),
      .chamber_vac(chamber_vac),
      .busy       (busy),
      .fault      (fault)
   );

   typedef struct {
      logic       inr;
      logic       outr;
      logic       ic;
      logic       oc;
      logic [6:0] exp;
      string      name;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [6:0] exp);
      logic [6:0] act;
      act = {open_inner, open_outer, pump_evac, pump_press, chamber_vac, busy, fault};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: outputs(oi oo ev pr vac busy fault) got %b expected %b", name, act, exp);
      end
      checks++;
      if ($countones(act[6:3]) > 1) begin
         failures++;
         $display("FAIL %s_mutex: commands got %b expected at most one high", name, act[6:3]);
      end
   endtask

   task automatic step(input logic i, input logic o, input logic ic, input logic oc);
      @(negedge Clock);
      inner_req   = i;
      outer_req   = o;
      InnerClosed = ic;
      OuterClosed = oc;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time got expired expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      Reset       = 1'b0;
      inner_req   = 1'b0;
      outer_req   = 1'b0;
      InnerClosed = 1'b1;
      OuterClosed = 1'b1;
      #2;
      check("reset_state", O_IDLE_P);
      @(negedge Clock);
      Reset = 1'b1;

      // Outbound passage, inbound passage and rest-state gating, one row per clock.
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, O_IDLE_P, "idle_p"});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, O_OPENI,  "inner_req_opens"});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, O_OPENI,  "inner_held_open"});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, O_SEAL_P, "inner_drop_seal"});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, O_SEAL_P, "seal_wait_door"});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, O_IDLE_P, "seal_to_rest_p"});
      for (int k = 0; k < EVAC_C; k++)
         tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, O_EVAC, "evac_pumping"});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, O_IDLE_V, "evac_done_rest_v"});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, O_OPENO,  "outer_opens"});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, O_OPENO,  "outer_held_open"});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, O_SEAL_V, "outer_drop_seal"});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, O_IDLE_V, "seal_to_rest_v"});
      for (int k = 0; k < PRESS_C; k++)
         tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, O_PRESS, "press_pumping"});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, O_IDLE_P, "press_done_rest_p"});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, O_OPENI,  "inner_opens_after"});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, O_SEAL_P, "inner_drop_seal2"});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, O_IDLE_P, "rest_p_again"});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, O_IDLE_P, "no_evac_door_open"});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, O_IDLE_P, "idle_p_end"});

      foreach (tbl[k]) begin
         step(tbl[k].inr, tbl[k].outr, tbl[k].ic, tbl[k].oc);
         check(tbl[k].name, tbl[k].exp);
      end

      // Asynchronous reset in the middle of the second EVAC cycle.
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("rst_evac_c1", O_EVAC);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("rst_evac_c2", O_EVAC);
      #2;
      Reset = 1'b0;
      #1;
      check("reset_mid_evac", O_IDLE_P);
      @(negedge Clock);
      outer_req = 1'b0;
      Reset     = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("after_reset_idle", O_IDLE_P);

      // Simultaneous requests at REST_P: inner first, then pump and open outer.
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("simul_inner_first", O_OPENI);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("simul_seal", O_SEAL_P);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("simul_rest_p", O_IDLE_P);
      for (int k = 0; k < EVAC_C; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1);
         check("simul_evac", O_EVAC);
      end
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("simul_rest_v", O_IDLE_V);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("simul_open_outer", O_OPENO);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("simul_seal_v", O_SEAL_V);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("simul_back_rest_v", O_IDLE_V);
      for (int k = 0; k < PRESS_C; k++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1);
         check("return_press", O_PRESS);
      end
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("return_rest_p", O_IDLE_P);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("return_open_inner", O_OPENI);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("return_seal", O_SEAL_P);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("return_idle", O_IDLE_P);

      // EVAC abort at pump cycle 2, then a full restart once the door recloses.
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("abort_evac_c1", O_EVAC);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("abort_evac_c2", O_EVAC);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("abort_to_seal", O_SEAL_P);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("abort_seal_hold", O_SEAL_P);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("abort_rest_p", O_IDLE_P);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      n = 0;
      while (pump_evac && n < 10) begin
         n++;
         step(1'b0, 1'b1, 1'b1, 1'b1);
      end
      checks++;
      if (n != EVAC_C) begin
         failures++;
         $display("FAIL restart_evac_len: pump cycles got %0d expected %0d", n, EVAC_C);
      end
      check("restart_rest_v", O_IDLE_V);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("restart_open_outer", O_OPENO);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("restart_seal_v", O_SEAL_V);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("restart_rest_v2", O_IDLE_V);

      // Inbound at vacuum: no PRESS while a door reports open, then 3-cycle PRESS.
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("no_press_door_open", O_IDLE_V);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      n = 0;
      while (pump_press && n < 10) begin
         n++;
         step(1'b1, 1'b0, 1'b1, 1'b1);
      end
      checks++;
      if (n != PRESS_C) begin
         failures++;
         $display("FAIL press_len: pump cycles got %0d expected %0d", n, PRESS_C);
      end
      check("inbound_rest_p", O_IDLE_P);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("inbound_open_inner", O_OPENI);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("inbound_seal", O_SEAL_P);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("inbound_idle", O_IDLE_P);

`ifdef AIRLOCK_SEAL_TIMEOUT_EN
      // Seal timeout: inner door stays open through SEAL_TIMEOUT cycles.
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("to_open_inner", O_OPENI);
      for (int k = 0; k < SEAL_T; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         check("seal_timing", O_SEAL_P);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("seal_timeout_fault", O_FAULT);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1);
         check("fault_sticky", O_FAULT);
      end
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      check("fault_reset", O_IDLE_P);
      @(negedge Clock);
      inner_req = 1'b0;
      outer_req = 1'b0;
      Reset     = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("fault_reset_idle", O_IDLE_P);
`else
      // Without the timeout, SEAL waits indefinitely with fault low.
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("to_open_inner", O_OPENI);
      for (int k = 0; k < SEAL_T + 4; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         check("seal_no_timeout", O_SEAL_P);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("seal_late_close", O_IDLE_P);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/airlock_sequencer.md
# airlock_sequencer

Sequencer for the two-door airlock chamber: arbitrates passage requests from the pressurized side and the vacuum side, and drives door-open commands and the evacuation and pressurization pumps in a fixed interlocked order. It sits above the door sensors and pump drivers and is the single source of pump and door commands. Both doors are never commanded open together, and no pump runs unless both doors report closed.

## Interface
Parameters:
- EVAC_CYCLES, 8, pump_evac on-time in cycles (≥1)
- PRESS_CYCLES, 8, pump_press on-time in cycles (≥1)
- SEAL_TIMEOUT, 16, cycles allowed in SEAL before fault (used only with macro)
- CNT_W, 8, timer width; every cycle parameter must be < 2^CNT_W

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- inner_req  in  1  passage request from the pressurized side; level, held until passage done
- outer_req  in  1  passage request from the vacuum side; level
- InnerClosed  in  1  inner door sensor, 1 = closed
- OuterClosed  in  1  outer door sensor, 1 = closed
- open_inner  out  1  inner door open command
- open_outer  out  1  outer door open command
- pump_evac  out  1  evacuation pump enable
- pump_press  out  1  pressurization pump enable
- chamber_vac  out  1  chamber at vacuum (vac_flag)
- busy  out  1  state is not REST_P or REST_V
- fault  out  1  seal-timeout fault; tied 0 without macro

## Operation
- Moore machine. All outputs decode from the state register and vac_flag only.
- REST_P (chamber pressurized, idle):
  - inner_req → OPEN_IN.
  - else outer_req & InnerClosed & OuterClosed → EVAC.
- REST_V (chamber at vacuum, idle):
  - outer_req → OPEN_OUT.
  - else inner_req & both closed → PRESS.
- Simultaneous requests in a rest state: the same-side door wins (inner at REST_P, outer at REST_V). The other request stays pending and is served after SEAL.
- OPEN_IN: open_inner=1. inner_req=0 → SEAL.
- OPEN_OUT: open_outer=1. outer_req=0 → SEAL.
- SEAL: no commands asserted. InnerClosed & OuterClosed → REST_V if vac_flag, else REST_P.
- EVAC: pump_evac=1; timer loaded with EVAC_CYCLES on entry.
  - Expiry → vac_flag←1, go to REST_V.
  - Either door sensor 0 → abort to SEAL immediately, pump off, vac_flag unchanged.
- PRESS: pump_press=1; timer loaded with PRESS_CYCLES.
  - Expiry → vac_flag←0, go to REST_P.
  - Door sensor 0 → abort to SEAL, vac_flag unchanged.
- A request from the far side is served by pumping first, then opening: outer_req at REST_P runs EVAC → REST_V → OPEN_OUT.
- Mutual exclusion: at most one of open_inner, open_outer, pump_evac, pump_press is high in any cycle.

## Timing
- Reset asserted (async): state=REST_P, vac_flag=0, timer=0, all outputs 0, taking effect immediately, including mid-pump. After reset the chamber is treated as pressurized.
- Request-to-door latency: the request is sampled at edge N; the door command is high from cycle N+1.
- Request drop: the door command falls the cycle after the request is sampled low.
- Pump assertion lasts exactly EVAC_CYCLES / PRESS_CYCLES cycles when not aborted.
- vac_flag updates on the same edge as the exit to the rest state.
- REST to OPEN on the far side after a pump completes: one extra cycle through the rest state.
- Door sensors are sampled every cycle in EVAC/PRESS. Abort takes effect on the next edge.

## Configuration
- AIRLOCK_SEAL_TIMEOUT_EN defined:
  - The timer counts in SEAL. If both doors are not closed within SEAL_TIMEOUT cycles, the machine enters FAULT.
  - FAULT: fault=1, all door and pump commands 0, busy=1. Only Reset exits FAULT.
- AIRLOCK_SEAL_TIMEOUT_EN undefined: SEAL waits indefinitely, no FAULT state, fault=0 constantly.

## Structure
- Package airlock_pkg:
  - state enum (REST_P, REST_V, OPEN_IN, OPEN_OUT, SEAL, EVAC, PRESS, FAULT)
  - encoding width constant
- Sub-module airlock_timer, CNT_W wide:
  - inputs load, load_val, en
  - output done, high when the count reaches 0
  - instantiated once and shared by EVAC, PRESS and SEAL.

## Test plan
- Reset mid-EVAC (EVAC_CYCLES=4, cycle 2): pump_evac drops asynchronously; state REST_P, chamber_vac=0.
- Full outbound passage, EVAC_CYCLES=4:
  - inner_req=1 → open_inner next cycle; drop req, doors closed → REST_P.
  - outer_req=1 → pump_evac high exactly 4 cycles, chamber_vac=1, open_outer one cycle after REST_V.
- Simultaneous inner_req=outer_req=1 at REST_P: open_inner first; after inner_req drops and SEAL completes, EVAC then OPEN_OUT.
- EVAC abort: OuterClosed=0 at pump cycle 2 → pump_evac 0 next cycle, SEAL, chamber_vac stays 0; re-closing restarts a full 4-cycle EVAC.
- Inbound at vacuum, PRESS_CYCLES=3: inner_req at REST_V → pump_press 3 cycles → chamber_vac=0 → open_inner.
- Macro on, SEAL_TIMEOUT=16: hold InnerClosed=0 in SEAL for 16 cycles → fault=1, all commands 0. Requests are ignored until Reset.
